// File: rtl/is_pkg_uart_controller.sv
// Shared types and constants for the UART controller blocks.
// The receive FIFO entry layout and the frame bit positions live here.
package is_pkg_uart_controller;

    localparam int RX_DIV_MIN  = 4;
    localparam int RX_STOP_BIT = 9;
    localparam int RX_PAR_BIT  = 8;

    typedef struct packed {
        logic       stop_err;
        logic       par_err;
        logic [7:0] data;
    } rx_entry_t;

    // A frame is bad when either status flag is raised
    function automatic logic rx_entry_bad(input rx_entry_t entry);
        return entry.stop_err | entry.par_err;
    endfunction

endpackage

// File: rtl/is_uart_rx_fifo.sv
// Show-ahead synchronous FIFO of received frame entries.
// A push is accepted when not full, or when a pop frees a slot in the same cycle.
module is_uart_rx_fifo
    import is_pkg_uart_controller::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      push_i,
    input  rx_entry_t data_i,
    input  logic      pop_i,
    output rx_entry_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    rx_entry_t       mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic            wr_en_s;
    logic            rd_en_s;

    // Extra pointer bit separates full from empty when the indices match
    assign empty_o = (wr_ptr_r == rd_ptr_r);
    assign full_o  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rd_en_s = pop_i & ~empty_o;
    assign wr_en_s = push_i & (~full_o | rd_en_s);
    assign data_o  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= data_i;
                wr_ptr_r                <= wr_ptr_r + PW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/is_uart_rx_ctrl.sv
// UART receive controller: RXD synchroniser, mid-bit strobe generator,
// frame FIFO with valid/ready read port, overrun and error statistics.
module is_uart_rx_ctrl
    import is_pkg_uart_controller::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             rxd_i,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             clr_i,
    output logic             rxd_rg_o,
    output logic             rx_ce_o,
    input  logic             rxct_r_i,
    input  logic             rx_data_en_i,
    input  logic [9:0]       rx_data_t_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [7:0]       rd_data_o,
    output logic [1:0]       rd_flags_o,
    output logic             ovr_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_r;
    logic             sync2_r;
    logic             rxd_rg_r;
    logic [DIV_W-1:0] div_eff_s;
    logic [DIV_W-1:0] bcnt_r;
    logic             rx_ce_r;
    logic             idle_s;
    rx_entry_t        entry_s;
    rx_entry_t        head_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             bad_s;
    logic             ovr_r;
    logic [CNT_W-1:0] err_cnt_r;

    assign idle_s = rxct_r_i | ~cfg_en_i;

    // Two-flop synchroniser plus output register; disabled receiver looks idle-high
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            rxd_rg_r <= 1'b1;
        end else begin
            sync1_r  <= rxd_i;
            sync2_r  <= sync1_r;
            rxd_rg_r <= cfg_en_i ? sync2_r : 1'b1;
        end
    end

    // Clamp the bit period to the minimum the half-bit alignment supports
    always_comb begin
        div_eff_s = cfg_div_i;
        if (cfg_div_i < DIV_W'(RX_DIV_MIN)) begin
            div_eff_s = DIV_W'(RX_DIV_MIN);
        end else begin
            div_eff_s = cfg_div_i;
        end
    end

    // Bit-period down-counter; the strobe is registered so it is high while bcnt is zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bcnt_r  <= '0;
            rx_ce_r <= 1'b0;
        end else if (idle_s) begin
            bcnt_r  <= div_eff_s >> 1;
            rx_ce_r <= 1'b0;
        end else if (bcnt_r == '0) begin
            bcnt_r  <= div_eff_s - DIV_W'(1);
            rx_ce_r <= 1'b0;
        end else begin
            bcnt_r  <= bcnt_r - DIV_W'(1);
            rx_ce_r <= (bcnt_r == DIV_W'(1));
        end
    end

    assign entry_s.stop_err = rx_data_t_i[RX_STOP_BIT];
    assign entry_s.par_err  = ~rx_data_t_i[RX_PAR_BIT];
    assign entry_s.data     = rx_data_t_i[7:0];
    assign bad_s            = rx_entry_bad(entry_s);
    assign push_s           = rx_data_en_i & cfg_en_i;
    assign pop_s            = ~empty_s & rd_ready_i;

    is_uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push_s),
        .data_i  (entry_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Sticky overrun and saturating bad-frame counter; clear wins
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovr_r     <= 1'b0;
            err_cnt_r <= '0;
        end else if (clr_i) begin
            ovr_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            if (push_s & full_s & ~pop_s) begin
                ovr_r <= 1'b1;
            end
            if (push_s & bad_s & (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
        end
    end

    assign rxd_rg_o   = rxd_rg_r;
    assign rx_ce_o    = rx_ce_r;
    assign rd_valid_o = ~empty_s;
    assign rd_data_o  = head_s.data;
    assign rd_flags_o = {head_s.stop_err, head_s.par_err};
    assign ovr_o      = ovr_r;
    assign err_cnt_o  = err_cnt_r;
    assign busy_o     = ~rxct_r_i & cfg_en_i;

endmodule

// File: tb/tb_is_uart_rx_ctrl.sv
// Self-checking bench for is_uart_rx_ctrl: a queue/arithmetic reference model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_is_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rstn;
    logic             rxd;
    logic             cfg_en;
    logic [DIV_W-1:0] cfg_div;
    logic             clr;
    logic             rxd_rg_o;
    logic             rx_ce_o;
    logic             rxct;
    logic             rx_data_en;
    logic [9:0]       rx_data_t;
    logic             rd_valid_o;
    logic             rd_ready;
    logic [7:0]       rd_data_o;
    logic [1:0]       rd_flags_o;
    logic             ovr_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             busy_o;

    is_uart_rx_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .rxd_i        (rxd),
        .cfg_en_i     (cfg_en),
        .cfg_div_i    (cfg_div),
        .clr_i        (clr),
        .rxd_rg_o     (rxd_rg_o),
        .rx_ce_o      (rx_ce_o),
        .rxct_r_i     (rxct),
        .rx_data_en_i (rx_data_en),
        .rx_data_t_i  (rx_data_t),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready),
        .rd_data_o    (rd_data_o),
        .rd_flags_o   (rd_flags_o),
        .ovr_o        (ovr_o),
        .err_cnt_o    (err_cnt_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int fall_cyc = 0;
    int strobe_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: pipeline history, busy-run length, frame queue
    logic       m_r1, m_r2, m_rg, m_ce, m_ovr;
    int         m_k, m_err;
    logic [9:0] m_q[$];

    always @(posedge clk or negedge rstn) begin
        int d, h;
        logic pop, push;
        logic [9:0] e;
        if (!rstn) begin
            m_r1 = 1'b1; m_r2 = 1'b1; m_rg = 1'b1; m_ce = 1'b0;
            m_k = 0; m_ovr = 1'b0; m_err = 0;
            m_q.delete();
        end else begin
            m_rg = cfg_en ? m_r2 : 1'b1;
            m_r2 = m_r1;
            m_r1 = rxd;
            d = (cfg_div < 4) ? 4 : int'(cfg_div);
            h = d / 2;
            if (rxct || !cfg_en) m_k = 0;
            else m_k++;
            m_ce = (m_k >= h) && (m_k > 0) && (((m_k - h) % d) == 0);
            pop  = (m_q.size() > 0) && rd_ready;
            push = rx_data_en && cfg_en;
            e    = {rx_data_t[9], ~rx_data_t[8], rx_data_t[7:0]};
            if (push && (e[9] || e[8]) && m_err < 255) m_err++;
            if (push && m_q.size() == DEPTH && !pop) m_ovr = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push && m_q.size() < DEPTH) m_q.push_back(e);
            if (clr) begin m_ovr = 1'b0; m_err = 0; end
        end
    end

    // Per-cycle comparison against the model, plus strobe timestamping
    always @(negedge clk) begin
        chk("rxd_rg", rxd_rg_o, m_rg);
        chk("rx_ce", rx_ce_o, m_ce);
        chk("busy", busy_o, ~rxct & cfg_en);
        chk("rd_valid", rd_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("rd_data", rd_data_o, m_q[0][7:0]);
            chk("rd_flags", rd_flags_o, m_q[0][9:8]);
        end
        chk("ovr", ovr_o, m_ovr);
        chk("err_cnt", err_cnt_o, m_err);
        if (rx_ce_o === 1'b1) strobe_q.push_back(cyc - fall_cyc);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
            rxd = cyc[2] ^ cyc[0];
        end
    endtask

    task automatic push_frame(input logic [9:0] raw);
        rx_data_t  = raw;
        rx_data_en = 1'b1;
        step(1);
        rx_data_en = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] d, input logic [1:0] f);
        chk("lit_valid", rd_valid_o, 1'b1);
        chk("lit_data", rd_data_o, d);
        chk("lit_flags", rd_flags_o, f);
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int t;
        t = 0;
        while (strobe_q.size() < n && t < budget) begin
            step(1);
            t++;
        end
        if (strobe_q.size() < n) chk("strobe_timeout", strobe_q.size(), n);
    endtask

    task automatic start_frame();
        strobe_q.delete();
        fall_cyc = cyc;
        rxct = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rxd = 1'b1; cfg_en = 1'b1; cfg_div = 16'd16; clr = 1'b0;
        rxct = 1'b1; rx_data_en = 1'b0; rx_data_t = 10'd0; rd_ready = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        step(3);
        chk("rst_valid", rd_valid_o, 1'b0);
        chk("rst_ce", rx_ce_o, 1'b0);
        chk("rst_rg", rxd_rg_o, 1'b1);
        rstn = 1'b1;
        step(3);
        chk("rst_err", err_cnt_o, 8'd0);

        // 1: full frame at divider 16, good 0x5A
        start_frame();
        wait_strobes(10, 200);
        chk("t1_n", strobe_q.size(), 10);
        chk("t1_first", strobe_q[0], 8);
        chk("t1_second", strobe_q[1], 24);
        chk("t1_last", strobe_q[9], 152);
        rxct = 1'b1;
        push_frame({1'b0, 1'b1, 8'h5A});
        chk("t1_err", err_cnt_o, 8'd0);
        pop_expect(8'h5A, 2'b00);
        chk("t1_empty", rd_valid_o, 1'b0);

        // 2: false start, then disable mid-frame and re-enable
        step(3);
        start_frame();
        wait_strobes(1, 50);
        rxct = 1'b1;
        step(30);
        chk("t2_n", strobe_q.size(), 1);
        chk("t2_first", strobe_q[0], 8);
        chk("t2_nopush", rd_valid_o, 1'b0);
        start_frame();
        step(5);
        cfg_en = 1'b0;
        step(5);
        chk("t2_dis_rg", rxd_rg_o, 1'b1);
        strobe_q.delete();
        fall_cyc = cyc;
        cfg_en = 1'b1;
        wait_strobes(1, 50);
        chk("t2_reen", strobe_q[0], 8);
        rxct = 1'b1;
        step(3);

        // 3: overflow with five frames
        for (int i = 1; i <= 5; i++) push_frame({1'b0, 1'b1, 8'(i)});
        chk("t3_ovr", ovr_o, 1'b1);
        for (int i = 1; i <= 4; i++) pop_expect(8'(i), 2'b00);
        chk("t3_empty", rd_valid_o, 1'b0);

        // 4: push and pop together while full
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("t4_clr", ovr_o, 1'b0);
        for (int i = 1; i <= 4; i++) push_frame({1'b0, 1'b1, 8'(i)});
        rx_data_t = {1'b0, 1'b1, 8'h06};
        rx_data_en = 1'b1;
        rd_ready = 1'b1;
        step(1);
        rx_data_en = 1'b0;
        rd_ready = 1'b0;
        chk("t4_noovr", ovr_o, 1'b0);
        pop_expect(8'h02, 2'b00);
        pop_expect(8'h03, 2'b00);
        pop_expect(8'h04, 2'b00);
        pop_expect(8'h06, 2'b00);

        // 5: error flags, counting, clear priority
        push_frame({1'b1, 1'b1, 8'h11});
        push_frame({1'b0, 1'b0, 8'h22});
        chk("t5_err2", err_cnt_o, 8'd2);
        rx_data_t = {1'b1, 1'b0, 8'h33};
        rx_data_en = 1'b1;
        clr = 1'b1;
        step(1);
        rx_data_en = 1'b0;
        clr = 1'b0;
        chk("t5_clr", err_cnt_o, 8'd0);
        pop_expect(8'h11, 2'b10);
        pop_expect(8'h22, 2'b01);
        pop_expect(8'h33, 2'b11);

        // 6: clamped divider, then reset mid-frame
        cfg_div = 16'd2;
        push_frame({1'b0, 1'b1, 8'h77});
        start_frame();
        wait_strobes(3, 50);
        chk("t6_s0", strobe_q[0], 2);
        chk("t6_s1", strobe_q[1], 6);
        chk("t6_s2", strobe_q[2], 10);
        rstn = 1'b0;
        #1;
        chk("t6_valid", rd_valid_o, 1'b0);
        chk("t6_ce", rx_ce_o, 1'b0);
        chk("t6_rg", rxd_rg_o, 1'b1);
        chk("t6_ovr", ovr_o, 1'b0);
        rxct = 1'b1;
        step(2);
        rstn = 1'b1;
        step(5);
        chk("t6_after", rd_valid_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
